registro_flags_ula: RTL
=======================

Name: registro_flags_ula

Overview:
- Registered, parametrised status unit for the ULA datapath.
- Accepts one ULA result per `res_valid` strobe and computes Z/OV/COUT/ERR for a generic result width.
- Holds the live flags, accumulates sticky flags, counts overflow and error events, and traps on division by zero until software clears it.
- Sits between the ULA combinational core and the display/control logic; the display-overflow limit is configurable.

Parameters:
- `W`, default 8: width of result `S`.
- `WB`, default 4: width of operand `B` (divisor).
- `LIMITE_DISPLAY`, default 99: largest unsigned result the BCD displays can show.
- `CNT_W`, default 8: width of the saturating event counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `res_valid`  in  1  the ULA result and side inputs are valid this cycle.
- `S`  in  W  ULA result.
- `B`  in  WB  operand B.
- `Sel`  in  3  ULA operation select (000 soma, 001 sub, 011 div).
- `soma_cmsb`  in  1  adder carry into the MSB.
- `soma_cout`  in  1  adder carry out.
- `sub_bmsb`  in  1  subtractor borrow into the MSB.
- `sub_bout`  in  1  subtractor borrow out.
- `clr_sticky`  in  1  synchronous clear of sticky flags, counters and trap.
- `irq_mask`  in  4  interrupt enable per sticky bit, order {ERR,COUT,OV,Z}.
- `Z`  out  1  live zero flag (registered).
- `OV`  out  1  live overflow flag (registered).
- `COUT`  out  1  live carry/borrow flag (registered).
- `ERR`  out  1  live division-by-zero flag (registered).
- `flags_valid`  out  1  one-cycle pulse: the live flags were updated on this edge.
- `sticky`  out  4  accumulated flags {ERR,COUT,OV,Z}.
- `ov_count`  out  CNT_W  number of captures with OV=1, saturating.
- `err_count`  out  CNT_W  number of captures with ERR=1, saturating.
- `trap`  out  1  high while the FSM is in ERRO.
- `irq`  out  1  `|(sticky & irq_mask)`, combinational from registers.

Behaviour:
- Reset (`rst_n`=0, asynchronous): all outputs 0, FSM = NORMAL. Applies immediately, including mid-capture.
- Next-state flag equations, evaluated from the inputs sampled on an accepted `res_valid`:
  - `z_n` = (S == 0).
  - `cout_n` = !Sel[1] & (Sel[0] ? sub_bout : soma_cout).
  - `ovar_n` = !Sel[1] & (Sel[0] ? (sub_bmsb ^ sub_bout) : (soma_cmsb ^ soma_cout)).
  - `ovdisp_n` = (S > LIMITE_DISPLAY), unsigned compare at W bits. If LIMITE_DISPLAY ≥ 2^W−1 the term is constant 0.
  - `ov_n` = ovar_n | ovdisp_n.
  - `err_n` = (Sel == 3'b011) & (B == 0).
- FSM has two states, NORMAL and ERRO.
- NORMAL, `res_valid`=1:
  - Register Z/OV/COUT/ERR on the edge.
  - Set `flags_valid`=1 for exactly one cycle; latency is 1 clock from `res_valid` to the updated flags.
  - `sticky` |= {err_n, cout_n, ov_n, z_n}.
  - `ov_count`++ if `ov_n`; `err_count`++ if `err_n`.
  - If `err_n`=1, go to ERRO.
- NORMAL, `res_valid`=0: live flags hold and `flags_valid`=0.
- ERRO:
  - `trap`=1.
  - `res_valid` is ignored: live flags, sticky, counters and `flags_valid` do not change (`flags_valid`=0).
  - Leave only via `clr_sticky`.
- `clr_sticky`=1 (either state):
  - Next edge: `sticky`=0, both counters=0, FSM goes to NORMAL.
  - Live Z/OV/COUT/ERR are not cleared.
- Simultaneous `clr_sticky` and accepted `res_valid` (NORMAL only):
  - The capture occurs and the new event wins: `sticky` = new flags, each counter = 1 if its flag is set else 0.
  - If `err_n`=1, the FSM enters ERRO.
  - In ERRO, `clr_sticky` wins and `res_valid` is still ignored that cycle.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `irq` follows `sticky`/`irq_mask` with no extra register stage.
- Back-to-back `res_valid` each cycle in NORMAL: every cycle is captured and `flags_valid` stays high continuously.

Test Plan:
1. Reset, then `res_valid` with S=0, Sel=000, soma_cout=0 → next cycle Z=1, OV=0, COUT=0, flags_valid pulse, sticky=4'b0001.
2. Sel=000, S=8'h80, soma_cmsb=1, soma_cout=0 → OV=1 (arithmetic and display > 99). Then S=100 with carries equal → OV=1, ov_count=2. Then S=99 → OV=0, ov_count=2.
3. Sel=001, sub_bout=1, sub_bmsb=1, S=8'hFF → COUT=1, OV=1 (display only). Then Sel=010 with the same carries → COUT=0.
4. Sel=011, B=0 → ERR=1, trap=1, err_count=1. Further `res_valid` pulses with S=5 → flags/counters unchanged, no flags_valid. Then clr_sticky → trap=0, sticky=0, counters=0, ERR still 1.
5. CNT_W=2, five OV captures → ov_count=3 (saturated). clr_sticky together with an OV capture in the same cycle → ov_count=1, sticky[1]=1.
6. irq_mask=4'b0100 with a COUT event → irq=1 the cycle after capture. Assert rst_n low mid-stream → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/registro_flags_ula_if.sv
// Bus between the ULA core and the status unit.
// The master side (ULA core or bench) drives the result, operand B, the
// operation select, adder/subtractor carries, clr_sticky and irq_mask.
// The slave side (registro_flags_ula) returns:
//   - the live flags Z/OV/COUT/ERR and the flags_valid pulse;
//   - the sticky flags and the saturating event counters;
//   - trap and irq.
interface registro_flags_ula_if #(
  parameter int W     = 8,
  parameter int WB    = 4,
  parameter int CNT_W = 8
);
  logic             res_valid;
  logic [W-1:0]     S;
  logic [WB-1:0]    B;
  logic [2:0]       Sel;
  logic             soma_cmsb;
  logic             soma_cout;
  logic             sub_bmsb;
  logic             sub_bout;
  logic             clr_sticky;
  logic [3:0]       irq_mask;

  logic             Z;
  logic             OV;
  logic             COUT;
  logic             ERR;
  logic             flags_valid;
  logic [3:0]       sticky;
  logic [CNT_W-1:0] ov_count;
  logic [CNT_W-1:0] err_count;
  logic             trap;
  logic             irq;

  modport master (
    output res_valid, S, B, Sel, soma_cmsb, soma_cout, sub_bmsb, sub_bout,
           clr_sticky, irq_mask,
    input  Z, OV, COUT, ERR, flags_valid, sticky, ov_count, err_count, trap, irq
  );

  modport slave (
    input  res_valid, S, B, Sel, soma_cmsb, soma_cout, sub_bmsb, sub_bout,
           clr_sticky, irq_mask,
    output Z, OV, COUT, ERR, flags_valid, sticky, ov_count, err_count, trap, irq
  );
endinterface

// File: rtl/registro_flags_ula.sv
// Registered status unit for the ULA datapath.
// Each accepted res_valid captures Z/OV/COUT/ERR from the ULA result. The
// unit also accumulates sticky flags and counts overflow and error events
// in saturating counters. A division by zero traps the unit until
// clr_sticky is pulsed.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - registro_flags_ula_if slave modport; carries the ULA result
//           and side inputs, and returns the flags, sticky, counters,
//           trap and irq
module registro_flags_ula #(
  parameter int W              = 8,
  parameter int WB             = 4,
  parameter int LIMITE_DISPLAY = 99,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  registro_flags_ula_if.slave  bus
);

  typedef enum logic {NORMAL = 1'b0, ERRO = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             z_n, cout_n, ovar_n, ovdisp_n, ov_n, err_n;
  logic             z_q, ov_q, cout_q, err_q, fv_q;
  logic [3:0]       sticky_q, sticky_base;
  logic [CNT_W-1:0] ov_cnt_q, err_cnt_q, ov_base, err_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Display overflow compares at W bits. It folds to 0 when every W-bit
  // value fits on the display.
  generate
    if (LIMITE_DISPLAY >= (1 << W) - 1) begin : g_no_disp
      assign ovdisp_n = 1'b0;
    end else begin : g_disp
      localparam logic [W-1:0] LIM = W'(LIMITE_DISPLAY);
      assign ovdisp_n = (bus.S > LIM);
    end
  endgenerate

  // Candidate flags from the current inputs. Sel[1] set means a
  // non-add/sub operation, so it has no carry or arithmetic overflow.
  always_comb begin
    z_n    = (bus.S == '0);
    cout_n = !bus.Sel[1] & (bus.Sel[0] ? bus.sub_bout : bus.soma_cout);
    ovar_n = !bus.Sel[1] & (bus.Sel[0] ? (bus.sub_bmsb ^ bus.sub_bout)
                                       : (bus.soma_cmsb ^ bus.soma_cout));
    ov_n   = ovar_n | ovdisp_n;
    err_n  = (bus.Sel == 3'b011) & (bus.B == '0);
  end

  // A result is accepted only in NORMAL. clr_sticky zeroes the base that
  // the accumulators build on, so a simultaneous capture lands on a clean
  // slate and the new event wins.
  always_comb begin
    accept      = (state == NORMAL) & bus.res_valid;
    sticky_base = bus.clr_sticky ? 4'b0000 : sticky_q;
    ov_base     = bus.clr_sticky ? '0 : ov_cnt_q;
    err_base    = bus.clr_sticky ? '0 : err_cnt_q;
  end

  // Next-state logic. ERRO is entered on an accepted division by zero and
  // is left only through clr_sticky; res_valid is ignored while in ERRO.
  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL: if (accept && err_n) state_nxt = ERRO;
      ERRO:   if (bus.clr_sticky)  state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  // State register, live flags, sticky flags and event counters. The live
  // flags deliberately survive clr_sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= NORMAL;
      z_q       <= 1'b0;
      ov_q      <= 1'b0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
      fv_q      <= 1'b0;
      sticky_q  <= 4'b0000;
      ov_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      fv_q  <= accept;
      if (accept) begin
        z_q    <= z_n;
        ov_q   <= ov_n;
        cout_q <= cout_n;
        err_q  <= err_n;
      end
      sticky_q  <= sticky_base | (accept ? {err_n, cout_n, ov_n, z_n} : 4'b0000);
      ov_cnt_q  <= (accept && ov_n)  ? sat_inc(ov_base)  : ov_base;
      err_cnt_q <= (accept && err_n) ? sat_inc(err_base) : err_base;
    end
  end

  // irq is combinational from sticky and irq_mask, with no extra register
  // stage.
  assign bus.Z           = z_q;
  assign bus.OV          = ov_q;
  assign bus.COUT        = cout_q;
  assign bus.ERR         = err_q;
  assign bus.flags_valid = fv_q;
  assign bus.sticky      = sticky_q;
  assign bus.ov_count    = ov_cnt_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.trap        = (state == ERRO);
  assign bus.irq         = |(sticky_q & bus.irq_mask);

endmodule
